// File: rtl/cobra_run_ctrl.sv
// cobra_run_ctrl: run/halt/single-step enable generator for the CYBERcobra core.
// Define COBRA_RUN_CTRL_BP_EN to build the PC breakpoint register and comparator.
module cobra_run_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [1:0]      cmd_op_i,
    input  logic [31:0]     cmd_arg_i,
    input  logic            brk_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            core_en_o,
    output logic            halted_o,
    output logic            bp_hit_o,
    output logic [31:0]     retired_o
);

    typedef enum logic [1:0] {
        ST_HALT,
        ST_RUN,
        ST_STEP
    } state_t;

    typedef enum logic [1:0] {
        OP_HALT   = 2'b00,
        OP_RUN    = 2'b01,
        OP_STEP   = 2'b10,
        OP_SET_BP = 2'b11
    } op_t;

    state_t           state;
    op_t              cmd_op;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] step_arg;
    logic [31:0]      retired;
    logic             accept;
    logic             bp_match;
    logic             core_en;
    logic             unused_bits;

    assign cmd_op   = op_t'(cmd_op_i);
    assign step_arg = cmd_arg_i[CNT_W-1:0];
    assign accept   = cmd_valid_i && cmd_ready_o;

    // Only the low argument bits matter; the reduction keeps the rest visibly consumed.
    assign unused_bits = ^{cmd_arg_i, pc_i};

`ifdef COBRA_RUN_CTRL_BP_EN
    logic [PC_W-1:0] bp_addr;
    logic            bp_valid;
    logic            first_run;
    logic            bp_hit;
    logic            set_bp;

    // first_run masks the comparator so a RUN issued while sitting on the
    // breakpoint address can execute that instruction instead of re-halting.
    assign bp_match = bp_valid && (pc_i == bp_addr) && !first_run && (state == ST_RUN);
    assign set_bp   = accept && (cmd_op == OP_SET_BP) &&
                      ((state == ST_HALT) || ((state == ST_RUN) && !brk_i && !bp_match));
    assign bp_hit_o = bp_hit;
`else
    assign bp_match = 1'b0;
    assign bp_hit_o = 1'b0;
`endif

    // Halts from brk_i or the breakpoint must suppress this very cycle's
    // instruction, so the enable is combinational rather than registered.
    assign core_en     = !rst_i && !brk_i &&
                         (((state == ST_RUN) && !bp_match) || (state == ST_STEP));
    assign core_en_o   = core_en;
    assign cmd_ready_o = (state != ST_STEP);
    assign halted_o    = (state == ST_HALT);
    assign retired_o   = retired;

    // Control FSM plus the retire counter; priority is brk_i, then breakpoint, then command.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_HALT;
            step_cnt <= '0;
            retired  <= '0;
`ifdef COBRA_RUN_CTRL_BP_EN
            bp_addr   <= '0;
            bp_valid  <= 1'b0;
            first_run <= 1'b0;
            bp_hit    <= 1'b0;
`endif
        end else begin
            if (core_en) begin
                retired <= retired + 32'd1;
            end

            case (state)
                ST_HALT: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_RUN: begin
                                state <= ST_RUN;
`ifdef COBRA_RUN_CTRL_BP_EN
                                first_run <= 1'b1;
                                bp_hit    <= 1'b0;
`endif
                            end
                            OP_STEP: begin
                                if (step_arg != '0) begin
                                    step_cnt <= step_arg;
                                    state    <= ST_STEP;
`ifdef COBRA_RUN_CTRL_BP_EN
                                    bp_hit <= 1'b0;
`endif
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end

                ST_RUN: begin
`ifdef COBRA_RUN_CTRL_BP_EN
                    first_run <= 1'b0;
`endif
                    if (brk_i) begin
                        state <= ST_HALT;
                    end
`ifdef COBRA_RUN_CTRL_BP_EN
                    else if (bp_match) begin
                        state  <= ST_HALT;
                        bp_hit <= 1'b1;
                    end
`endif
                    else if (accept && (cmd_op == OP_HALT)) begin
                        state <= ST_HALT;
                    end
                end

                ST_STEP: begin
                    if (brk_i) begin
                        state    <= ST_HALT;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt - CNT_W'(1);
                        if (step_cnt == CNT_W'(1)) begin
                            state <= ST_HALT;
                        end
                    end
                end

                default: begin
                    state <= ST_HALT;
                end
            endcase

`ifdef COBRA_RUN_CTRL_BP_EN
            if (set_bp) begin
                if (cmd_arg_i == 32'hFFFF_FFFF) begin
                    bp_valid <= 1'b0;
                end else begin
                    bp_addr  <= cmd_arg_i[PC_W-1:0];
                    bp_valid <= 1'b1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cobra_run_ctrl.sv
// Directed scoreboard bench for cobra_run_ctrl; a small PC model advances by 4 per enabled cycle.
// Expectations adapt to COBRA_RUN_CTRL_BP_EN when the design is built with breakpoints.
module tb_cobra_run_ctrl;

    localparam logic [1:0] OP_HALT   = 2'b00;
    localparam logic [1:0] OP_RUN    = 2'b01;
    localparam logic [1:0] OP_STEP   = 2'b10;
    localparam logic [1:0] OP_SET_BP = 2'b11;

    localparam int SEL_EN      = 0;
    localparam int SEL_HALTED  = 1;
    localparam int SEL_READY   = 2;
    localparam int SEL_BPHIT   = 3;
    localparam int SEL_RETIRED = 4;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmdValid = 1'b0;
    logic [1:0]  cmdOp = 2'b00;
    logic [31:0] cmdArg = 32'd0;
    logic        brk = 1'b0;
    logic        pcReset = 1'b1;
    logic [31:0] pc;
    logic        cmdReady;
    logic        coreEn;
    logic        halted;
    logic        bpHit;
    logic [31:0] retired;

    expect_t     sbQueue[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] expRetired;

    cobra_run_ctrl #(
        .PC_W (32),
        .CNT_W(16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cmd_valid_i(cmdValid),
        .cmd_ready_o(cmdReady),
        .cmd_op_i   (cmdOp),
        .cmd_arg_i  (cmdArg),
        .brk_i      (brk),
        .pc_i       (pc),
        .core_en_o  (coreEn),
        .halted_o   (halted),
        .bp_hit_o   (bpHit),
        .retired_o  (retired)
    );

    always #5 clk = ~clk;

    // Core PC model: advances only on cycles the controller enabled.
    always @(posedge clk) begin
        if (pcReset) begin
            pc <= 32'd0;
        end else if (coreEn) begin
            pc <= pc + 32'd4;
        end
    end

    task automatic expectVal(input string tag, input int sel, input logic [31:0] val);
        expect_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sbQueue.push_back(e);
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            SEL_EN:      return {31'd0, coreEn};
            SEL_HALTED:  return {31'd0, halted};
            SEL_READY:   return {31'd0, cmdReady};
            SEL_BPHIT:   return {31'd0, bpHit};
            default:     return retired;
        endcase
    endfunction

    task automatic applyStimulus(input logic valid, input logic [1:0] op, input logic [31:0] arg);
        cmdValid = valid;
        cmdOp    = op;
        cmdArg   = arg;
    endtask

    // Drain every expectation queued for this cycle at the falling edge, then move to the next cycle.
    task automatic checkOutput();
        expect_t     e;
        logic [31:0] obs;
        @(negedge clk);
        while (sbQueue.size() > 0) begin
            e   = sbQueue.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.val) else begin
                errors++;
                $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired: checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset and idle
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        pcReset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        expectVal("reset_en", SEL_EN, 0);
        expectVal("reset_halted", SEL_HALTED, 1);
        expectVal("reset_ready", SEL_READY, 1);
        expectVal("reset_bphit", SEL_BPHIT, 0);
        expectVal("reset_retired", SEL_RETIRED, 0);
        checkOutput();

        // STEP 3 then STEP 0
        applyStimulus(1'b1, OP_STEP, 32'd3);
        expectVal("step3_accept_en", SEL_EN, 0);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        for (int i = 0; i < 3; i++) begin
            expectVal("step3_en", SEL_EN, 1);
            expectVal("step3_ready", SEL_READY, 0);
            expectVal("step3_halted", SEL_HALTED, 0);
            checkOutput();
        end
        expectVal("step3_done_en", SEL_EN, 0);
        expectVal("step3_done_halted", SEL_HALTED, 1);
        expectVal("step3_done_retired", SEL_RETIRED, 3);
        checkOutput();
        expRetired = 32'd3;

        applyStimulus(1'b1, OP_STEP, 32'd0);
        expectVal("step0_accept_en", SEL_EN, 0);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        expectVal("step0_en", SEL_EN, 0);
        expectVal("step0_halted", SEL_HALTED, 1);
        expectVal("step0_ready", SEL_READY, 1);
        checkOutput();
        expectVal("step0_retired", SEL_RETIRED, expRetired);
        checkOutput();

        // Breakpoint at 0x10 with the PC counting from 0
        applyStimulus(1'b1, OP_SET_BP, 32'h10);
        checkOutput();
        applyStimulus(1'b1, OP_RUN, 32'd0);
        pcReset = 1'b1;
        expectVal("bp_run_accept_en", SEL_EN, 0);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        pcReset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expectVal("bp_run_en", SEL_EN, 1);
            checkOutput();
        end
`ifdef COBRA_RUN_CTRL_BP_EN
        expectVal("bp_stop_en", SEL_EN, 0);
        checkOutput();
        expectVal("bp_stop_halted", SEL_HALTED, 1);
        expectVal("bp_stop_hit", SEL_BPHIT, 1);
        expectVal("bp_stop_retired", SEL_RETIRED, expRetired + 32'd4);
        checkOutput();
        applyStimulus(1'b1, OP_RUN, 32'd0);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        expectVal("bp_resume_en", SEL_EN, 1);
        expectVal("bp_resume_hit", SEL_BPHIT, 0);
        checkOutput();
        expectVal("bp_resume2_en", SEL_EN, 1);
        checkOutput();
        applyStimulus(1'b1, OP_HALT, 32'd0);
        expectVal("halt_accept_en", SEL_EN, 1);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        expRetired = expRetired + 32'd7;
`else
        expectVal("nobp_pass_en", SEL_EN, 1);
        expectVal("nobp_pass_hit", SEL_BPHIT, 0);
        checkOutput();
        applyStimulus(1'b1, OP_HALT, 32'd0);
        expectVal("halt_accept_en", SEL_EN, 1);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        expRetired = expRetired + 32'd6;
`endif
        expectVal("halt_after_en", SEL_EN, 0);
        expectVal("halt_after_halted", SEL_HALTED, 1);
        expectVal("halt_after_retired", SEL_RETIRED, expRetired);
        checkOutput();

        // Clear the breakpoint, RUN, brk_i pulse in cycle 20
        applyStimulus(1'b1, OP_SET_BP, 32'hFFFF_FFFF);
        checkOutput();
        applyStimulus(1'b1, OP_RUN, 32'd0);
        pcReset = 1'b1;
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        pcReset = 1'b0;
        for (int i = 1; i < 20; i++) begin
            expectVal("brk_run_en", SEL_EN, 1);
            if (i == 1) begin
                expectVal("brk_run_ready", SEL_READY, 1);
            end
            checkOutput();
        end
        brk = 1'b1;
        expectVal("brk_en", SEL_EN, 0);
        checkOutput();
        brk = 1'b0;
        expRetired = expRetired + 32'd19;
        expectVal("brk_halted", SEL_HALTED, 1);
        expectVal("brk_retired", SEL_RETIRED, expRetired);
        checkOutput();

        // brk_i during STEP 100 discards the remaining count
        applyStimulus(1'b1, OP_STEP, 32'd100);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        for (int i = 0; i < 5; i++) begin
            expectVal("step100_en", SEL_EN, 1);
            checkOutput();
        end
        brk = 1'b1;
        expectVal("step_brk_en", SEL_EN, 0);
        checkOutput();
        brk = 1'b0;
        expRetired = expRetired + 32'd5;
        expectVal("step_brk_halted", SEL_HALTED, 1);
        expectVal("step_brk_ready", SEL_READY, 1);
        expectVal("step_brk_retired", SEL_RETIRED, expRetired);
        checkOutput();
        expectVal("step_discard_en", SEL_EN, 0);
        checkOutput();

        // A STEP held during STEP waits for cmd_ready_o
        applyStimulus(1'b1, OP_STEP, 32'd2);
        checkOutput();
        applyStimulus(1'b1, OP_STEP, 32'd1);
        for (int i = 0; i < 2; i++) begin
            expectVal("held_step_en", SEL_EN, 1);
            expectVal("held_step_ready", SEL_READY, 0);
            checkOutput();
        end
        expectVal("held_accept_en", SEL_EN, 0);
        expectVal("held_accept_ready", SEL_READY, 1);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        expectVal("held_second_en", SEL_EN, 1);
        expectVal("held_second_halted", SEL_HALTED, 0);
        checkOutput();
        expRetired = expRetired + 32'd3;
        expectVal("held_done_halted", SEL_HALTED, 1);
        expectVal("held_done_retired", SEL_RETIRED, expRetired);
        checkOutput();

        // Reset mid-RUN with a breakpoint armed at 0x8
        applyStimulus(1'b1, OP_SET_BP, 32'h8);
        checkOutput();
        applyStimulus(1'b1, OP_RUN, 32'd0);
        pcReset = 1'b1;
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        pcReset = 1'b0;
        expectVal("prereset_en", SEL_EN, 1);
        checkOutput();
        rst = 1'b1;
        expectVal("midrst_en", SEL_EN, 0);
        expectVal("midrst_halted", SEL_HALTED, 1);
        expectVal("midrst_retired", SEL_RETIRED, 0);
        checkOutput();
        rst = 1'b0;
        applyStimulus(1'b1, OP_RUN, 32'd0);
        pcReset = 1'b1;
        expectVal("postrst_bphit", SEL_BPHIT, 0);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        pcReset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expectVal("postrst_run_en", SEL_EN, 1);
            checkOutput();
        end
        applyStimulus(1'b1, OP_HALT, 32'd0);
        expectVal("postrst_halt_en", SEL_EN, 1);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        expectVal("postrst_halted", SEL_HALTED, 1);
        expectVal("postrst_retired", SEL_RETIRED, 4);
        checkOutput();

        // Retire counter wrap
        force dut.retired = 32'hFFFF_FFFF;
        #1;
        release dut.retired;
        applyStimulus(1'b1, OP_STEP, 32'd1);
        expectVal("wrap_preload", SEL_RETIRED, 32'hFFFF_FFFF);
        checkOutput();
        applyStimulus(1'b0, OP_HALT, 32'd0);
        expectVal("wrap_step_en", SEL_EN, 1);
        checkOutput();
        expectVal("wrap_retired", SEL_RETIRED, 0);
        expectVal("wrap_halted", SEL_HALTED, 1);
        checkOutput();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
